// File: rtl/sad_pkg.sv
// Shared definitions for the SAD motion-search controller: default pixel width,
// SAD accumulator width and the search FSM state encoding.
package sad_pkg;

  localparam int DWIDTH = 8;
  localparam int SAD_W  = DWIDTH + 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sad_tag_pipe.sv
// Delay line that carries {valid, dx, dy} alongside each SAD_Cal request so the
// candidate tag leaves the pipe in the same cycle as the matching sad_vld.
module sad_tag_pipe #(
  parameter int PIPE_STAGE = 5,
  parameter int CW         = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tag_vld,
  input  logic [CW-1:0] tag_dx,
  input  logic [CW-1:0] tag_dy,
  output logic          exit_vld,
  output logic [CW-1:0] exit_dx,
  output logic [CW-1:0] exit_dy,
  output logic          pipe_busy
);

  logic [PIPE_STAGE-1:0] vld_q;
  logic [CW-1:0]         dx_q [PIPE_STAGE];
  logic [CW-1:0]         dy_q [PIPE_STAGE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_STAGE; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= tag_vld;
      dx_q[0]  <= tag_dx;
      dy_q[0]  <= tag_dy;
      for (int i = 1; i < PIPE_STAGE; i++) begin
        vld_q[i] <= vld_q[i-1];
        dx_q[i]  <= dx_q[i-1];
        dy_q[i]  <= dy_q[i-1];
      end
    end
  end

  // The exiting stage counts as occupied so DRAIN waits for its result.
  assign exit_vld  = vld_q[PIPE_STAGE-1];
  assign exit_dx   = dx_q[PIPE_STAGE-1];
  assign exit_dy   = dy_q[PIPE_STAGE-1];
  assign pipe_busy = |vld_q;

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search motion estimation controller: walks a +/-RANGE window in raster
// order, feeds SAD_Cal, and keeps the first candidate with the minimum SAD.
module sad_search_ctrl #(
  parameter  int DWIDTH     = sad_pkg::DWIDTH,
  parameter  int PIPE_STAGE = 5,
  parameter  int RANGE      = 8,
  localparam int CW         = $clog2(RANGE) + 2,
  localparam int SAD_W      = DWIDTH + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ref_rdy,
  output logic [CW-1:0]    cand_dx,
  output logic [CW-1:0]    cand_dy,
  output logic             cal_en,
  input  logic [SAD_W-1:0] sad,
  input  logic             sad_vld,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [CW-1:0]    best_dx,
  output logic [CW-1:0]    best_dy,
  output logic             err
);

  import sad_pkg::state_e;
  import sad_pkg::IDLE;
  import sad_pkg::ISSUE;
  import sad_pkg::DRAIN;
  import sad_pkg::DONE;

  localparam logic [CW-1:0] POS_R = CW'(RANGE);
  localparam logic [CW-1:0] NEG_R = CW'(-RANGE);

  state_e        state, state_nxt;
  logic          launch;
  logic          last_cand;
  logic          exit_vld;
  logic [CW-1:0] exit_dx;
  logic [CW-1:0] exit_dy;
  logic          pipe_busy;

  assign launch    = (state == IDLE) && start;
  assign last_cand = (cand_dx == POS_R) && (cand_dy == POS_R);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cal_en    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        cal_en = ref_rdy;
        if (ref_rdy && last_cand) state_nxt = DRAIN;
      end
      DRAIN:   if (!pipe_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster walk: dx is the inner loop; the final candidate is held once issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_dx <= '0;
      cand_dy <= '0;
    end else if (launch) begin
      cand_dx <= NEG_R;
      cand_dy <= NEG_R;
    end else if (cal_en && !last_cand) begin
      if (cand_dx == POS_R) begin
        cand_dx <= NEG_R;
        cand_dy <= cand_dy + CW'(1);
      end else begin
        cand_dx <= cand_dx + CW'(1);
      end
    end
  end

  sad_tag_pipe #(
    .PIPE_STAGE(PIPE_STAGE),
    .CW        (CW)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_vld  (cal_en),
    .tag_dx   (cand_dx),
    .tag_dy   (cand_dy),
    .exit_vld (exit_vld),
    .exit_dx  (exit_dx),
    .exit_dy  (exit_dy),
    .pipe_busy(pipe_busy)
  );

  // Strict less-than keeps the earliest candidate on ties; an untagged or
  // missing result flags err and never touches the running best.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
      err      <= 1'b0;
    end else if (launch) begin
      best_sad <= '1;
      best_dx  <= '0;
      best_dy  <= '0;
      err      <= 1'b0;
    end else begin
      if (exit_vld != sad_vld) err <= 1'b1;
      if (exit_vld && sad_vld && (sad < best_sad)) begin
        best_sad <= sad;
        best_dx  <= exit_dx;
        best_dy  <= exit_dy;
      end
    end
  end

endmodule
